// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU data
// port (fixed priority) and a host/debug port with starvation relief.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [7:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic [7:0]  mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [15:0] host_grants
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] ONE_W = WAIT_W'(1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0]       host_rdata_q, host_rdata_d;
  logic [15:0]       host_grants_q, host_grants_d;
  logic              grant;
  logic              in_resp;

  assign in_resp = (state_q == RESP);

  always_comb begin
    grant = 1'b0;
    if (state_q == IDLE) begin
      grant = host_req && (!cpu_en || (wait_cnt_q == MAX_W));
    end
  end

  // Memory port mux; reset gates the write strobe and stall.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_we    = cpu_we & cpu_en;
    mem_wdata = cpu_wdata;
    cpu_stall = 1'b0;
    if (grant) begin
      mem_addr  = host_addr;
      mem_we    = host_we;
      mem_wdata = host_wdata;
      cpu_stall = cpu_en;
    end
    if (reset) begin
      mem_we    = 1'b0;
      cpu_stall = 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    host_rdata_d  = host_rdata_q;
    host_grants_d = host_grants_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d    = RESP;
          wait_cnt_d = '0;
        end else if (host_req) begin
          if (wait_cnt_q != MAX_W) begin
            wait_cnt_d = wait_cnt_q + ONE_W;
          end
        end else begin
          wait_cnt_d = '0;
        end
      end
      RESP: begin
        state_d       = IDLE;
        host_rdata_d  = mem_rdata;
        host_grants_d = host_grants_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      host_rdata_q  <= '0;
      host_grants_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      host_rdata_q  <= host_rdata_d;
      host_grants_q <= host_grants_d;
    end
  end

  // Read data is live during the ack cycle, then held.
  assign host_ack    = in_resp;
  assign host_rdata  = in_resp ? mem_rdata : host_rdata_q;
  assign host_grants = host_grants_q;
  assign cpu_rdata   = mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 256x16 data memory between the CPU data port and a host/debug port (program loader, memory dump).
- Sits between the cpu data signals (dw, data_address, smdr1, read_data) and data_memory in cpu_top.
- The CPU has fixed priority. Host requests are serviced in CPU idle cycles.
- A starvation counter forces a host slot, with a one-cycle CPU stall, after MAX_WAIT denied cycles.

Parameters:
- MAX_WAIT, 4: number of consecutive denied host cycles before the host is forced a slot; range 1..15.
- WAIT_W, 4: width of the wait counter; must hold MAX_WAIT.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_en  in  1  CPU data access valid this cycle
- cpu_we  in  1  CPU write enable
- cpu_addr  in  8  CPU data address
- cpu_wdata  in  16  CPU write data
- cpu_rdata  out  16  CPU read data; combinational copy of mem_rdata
- cpu_stall  out  1  CPU access this cycle was not performed; CPU must hold and retry
- host_req  in  1  host access request; level, held until host_ack
- host_we  in  1  host write enable; stable while host_req=1
- host_addr  in  8  host address; stable while host_req=1
- host_wdata  in  16  host write data; stable while host_req=1
- host_ack  out  1  one-cycle pulse: host access complete
- host_rdata  out  16  host read data; valid when host_ack=1
- mem_addr  out  8  to data_memory address
- mem_we  out  1  to data_memory we
- mem_wdata  out  16  to data_memory write_data
- mem_rdata  in  16  from data_memory read_data; synchronous read, 1-cycle latency
- host_grants  out  16  count of completed host accesses, wraps at 0xFFFF->0

Behaviour:
- One clock (clock). Reset is asynchronous, active-high.
- Reset values: state=IDLE, wait_cnt=0, host_ack=0, host_rdata=0, host_grants=0.
- While reset=1: mem_we=0, cpu_stall=0.
- FSM states: IDLE and RESP.
- grant (combinational, IDLE only) = host_req && (!cpu_en || wait_cnt==MAX_WAIT).
- Mux in IDLE with grant=1:
  - mem_addr/mem_we/mem_wdata = host_addr/host_we/host_wdata.
  - cpu_stall = cpu_en.
- Mux in all other cycles (IDLE without grant, and RESP):
  - mem_* = cpu_addr/(cpu_we&cpu_en)/cpu_wdata.
  - cpu_stall = 0.
- IDLE -> RESP on grant. RESP -> IDLE unconditionally.
- host_req is ignored in RESP, so there is at most one host access per 2 cycles.
- CPU is never stalled in RESP and never stalled two cycles in a row.
- In RESP:
  - host_ack=1.
  - host_rdata = mem_rdata, which holds the data read at the grant edge.
  - host_rdata register captures mem_rdata at the RESP edge and holds it afterwards.
  - host_grants increments at the RESP edge.
  - For host writes, host_ack still pulses; host_rdata content is don't-care.
- wait_cnt:
  - In IDLE with host_req=1 and no grant: increments, saturating at MAX_WAIT.
  - Cleared on grant, and cleared in IDLE when host_req=0.
  - Held in RESP.
- The host must deassert host_req, or present a new request, in the cycle after host_ack. A request still high in that IDLE cycle is treated as a new access.
- cpu_rdata = mem_rdata always. The CPU must discard read data belonging to a stalled access.
- A forced grant while the CPU is writing: the CPU write is not performed (cpu_stall=1) and is retried by the CPU next cycle.
- Reset asserted in RESP: return to IDLE, no host_ack issued, host_grants not incremented. The host re-issues its request after reset.
- Simultaneous cpu_en=0 and host_req=1 at wait_cnt=MAX_WAIT: normal grant, cpu_stall=0.

Test Plan:
- Idle-CPU host write: cpu_en=0, host_req=1, we=1, addr=0x10, wdata=0xBEEF.
  -> mem_we=1, mem_addr=0x10 in cycle 0; host_ack=1 in cycle 1; host_grants=1.
  -> A later host read of 0x10 returns host_rdata=0xBEEF with host_ack.
- CPU priority: cpu_en=1 continuous read stream, host_req=1 read of addr 0x20, MAX_WAIT=4.
  -> 4 denied cycles with cpu_stall=0.
  -> Cycle 5: mem_addr=0x20, cpu_stall=1.
  -> Cycle 6: host_ack=1, cpu_stall=0.
- Back-to-back host requests with CPU idle: host_req held high for 3 accesses.
  -> host_ack pulses every 2nd cycle; host_grants=3.
- CPU write under forced grant: cpu_we=1, cpu_addr=0x05, cpu_wdata=0x1234 in the forced-slot cycle.
  -> Memory at 0x05 unchanged that cycle; the CPU retry next cycle writes 0x1234.
  -> A host read of 0x05 afterwards returns 0x1234.
- Reset mid-RESP: assert reset in the RESP cycle.
  -> host_ack=0, state=IDLE, host_grants=0, mem_we=0 while reset=1.
- Counter wrap: force host_grants to 0xFFFF via 65535 accesses, or a preloaded bench.
  -> Next ack wraps it to 0x0000.
